// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS-subset CPU: opcodes, R-type function codes,
// ALU operation codes and the decoded control bundle.
package cpu_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;

  // ALU operation select driven towards the ALU
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Full set of datapath controls produced by the decoder
  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  // All-zero control word: the NOP decode used for unknown encodings
  localparam ctrl_t CTRL_NOP = '{
    reg_dst:    1'b0,
    alu_src:    1'b0,
    mem_to_reg: 1'b0,
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    alu_op:     ALU_ADD
  };

  // Maps an R-type funct field to an ALU operation; valid=0 for unsupported codes
  function automatic logic rtype_alu_op(input logic [5:0] funct, output alu_op_e op);
    op = ALU_ADD;
    unique case (funct)
      FN_ADD:  begin op = ALU_ADD; return 1'b1; end
      FN_SUB:  begin op = ALU_SUB; return 1'b1; end
      FN_AND:  begin op = ALU_AND; return 1'b1; end
      FN_OR:   begin op = ALU_OR;  return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_control_unit_mux2_32.sv
// Generic 2:1 multiplexer; sel=0 passes in0, sel=1 passes in1.
// Default width is the 32-bit datapath; narrower instances are allowed.
module mux2_32 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule

// File: rtl/decode_control_unit.sv
// Decode/control stage of the single-cycle MIPS-subset CPU.
// Holds the instruction register, slices it into fields, generates the
// datapath controls, sign-extends the immediate and hosts the ALU operand-B
// and write-back multiplexers.
module decode_control_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_en,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm,
  output logic [DATA_W-1:0] sx_out,
  output logic [4:0]        wr_reg,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] ir_d;
  ctrl_t             ctrl;
  logic [5:0]        funct;

  // IR next state: load a new instruction only when fetch presents one
  always_comb begin
    ir_d = ir_q;
    if (instr_en) begin
      ir_d = instr_in;
    end
  end

  // IR register; reset clears it to the all-zero NOP instruction at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q <= '0;
    end else begin
      ir_q <= ir_d;
    end
  end

  // Field slicing: purely combinational views of the IR
  assign instr  = ir_q;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm    = ir_q[15:0];
  assign funct  = ir_q[5:0];
  assign sx_out = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};

  // Control table; anything not recognised decodes to the all-zero NOP
  always_comb begin
    alu_op_e fn_op;
    logic    fn_ok;
    ctrl  = CTRL_NOP;
    fn_op = ALU_ADD;
    fn_ok = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        fn_ok = rtype_alu_op(funct, fn_op);
        if (fn_ok) begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.alu_op    = fn_op;
        end
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  assign reg_dst    = ctrl.reg_dst;
  assign alu_src    = ctrl.alu_src;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign branch     = ctrl.branch;
  assign alu_op     = ctrl.alu_op;

  // Destination register select: rd for R-type, rt otherwise
  mux2_32 #(.WIDTH(5)) u_wr_reg_mux (
    .sel (ctrl.reg_dst),
    .in0 (rt),
    .in1 (rd),
    .out (wr_reg)
  );

  // ALU operand B: register data or sign-extended immediate
  mux2_32 #(.WIDTH(DATA_W)) u_alu_b_mux (
    .sel (ctrl.alu_src),
    .in0 (read_data2),
    .in1 (sx_out),
    .out (alu_b)
  );

  // Write-back data: ALU result or memory load data
  mux2_32 #(.WIDTH(DATA_W)) u_wb_mux (
    .sel (ctrl.mem_to_reg),
    .in0 (alu_out),
    .in1 (mem_data),
    .out (wb_data)
  );

endmodule

// File: tb/tb_decode_control_unit.sv
// Testbench for decode_control_unit: directed instruction steps followed by
// randomized instructions, compared against a reference model of the
// decode rules kept in this file.
module tb_decode_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_en;
  logic [31:0] instr_in;
  logic [31:0] read_data2;
  logic [31:0] alu_out;
  logic [31:0] mem_data;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [31:0] sx_out;
  logic [4:0]  wr_reg;
  logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
  logic [1:0]  alu_op;
  logic [31:0] alu_b;
  logic [31:0] wb_data;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: the instruction the DUT is expected to be holding
  logic [31:0] m_ir;

  always #5 clk = ~clk;

  decode_control_unit #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_en   (instr_en),
    .instr_in   (instr_in),
    .read_data2 (read_data2),
    .alu_out    (alu_out),
    .mem_data   (mem_data),
    .instr      (instr),
    .opcode     (opcode),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm        (imm),
    .sx_out     (sx_out),
    .wr_reg     (wr_reg),
    .reg_dst    (reg_dst),
    .alu_src    (alu_src),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .branch     (branch),
    .alu_op     (alu_op),
    .alu_b      (alu_b),
    .wb_data    (wb_data)
  );

  // Control word layout: {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op[1:0]}
  function automatic logic [8:0] dut_ctl();
    return {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
  endfunction

  // Reference decode written straight from the instruction table
  function automatic logic [8:0] ref_ctl(input logic [31:0] ir);
    int op;
    int fn;
    op = int'(ir >> 26);
    fn = int'(ir & 32'h3F);
    if (op == 0) begin
      if (fn == 32) return 9'b1001000_00;
      if (fn == 34) return 9'b1001000_01;
      if (fn == 36) return 9'b1001000_10;
      if (fn == 37) return 9'b1001000_11;
      return 9'b0;
    end
    if (op == 35) return 9'b0111100_00;
    if (op == 43) return 9'b0100010_00;
    if (op == 4)  return 9'b0000001_01;
    if (op == 8)  return 9'b0101000_00;
    return 9'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the current IR and inputs
  task automatic check_all(input string tag);
    logic [8:0]  e;
    logic [31:0] sx;
    int          dst;
    e   = ref_ctl(m_ir);
    sx  = (m_ir[15] ? 32'hFFFF0000 : 32'h0) | (m_ir & 32'hFFFF);
    dst = e[8] ? int'((m_ir >> 11) & 32'h1F) : int'((m_ir >> 16) & 32'h1F);
    chk({tag, ".instr"},  instr, m_ir);
    chk({tag, ".opcode"}, 32'(opcode), m_ir >> 26);
    chk({tag, ".rs"},     32'(rs), (m_ir >> 21) & 32'h1F);
    chk({tag, ".rt"},     32'(rt), (m_ir >> 16) & 32'h1F);
    chk({tag, ".rd"},     32'(rd), (m_ir >> 11) & 32'h1F);
    chk({tag, ".imm"},    32'(imm), m_ir & 32'hFFFF);
    chk({tag, ".sx"},     sx_out, sx);
    chk({tag, ".wr_reg"}, 32'(wr_reg), 32'(dst));
    chk({tag, ".ctl"},    32'(dut_ctl()), 32'(e));
    chk({tag, ".alu_b"},  alu_b, e[7] ? sx : read_data2);
    chk({tag, ".wb"},     wb_data, e[6] ? mem_data : alu_out);
    chk({tag, ".rw_excl"}, 32'(mem_read & mem_write), 32'h0);
  endtask

  // One clock edge; the model captures exactly when the DUT should
  task automatic tick();
    @(posedge clk);
    if (rst_n === 1'b1 && instr_en === 1'b1) m_ir = instr_in;
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    instr_en = 1'b1;
    instr_in = w;
    tick();
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    logic [31:0] w;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h00};

    // Reset held with a capture pending
    rst_n      = 1'b0;
    instr_en   = 1'b1;
    instr_in   = 32'h8C240008;
    read_data2 = 32'h0000_1234;
    alu_out    = 32'h0000_5678;
    mem_data   = 32'h9ABC_DEF0;
    m_ir       = 32'h0;
    #1;
    check_all("rst0");
    chk("rst0.alu_b_pass", alu_b, 32'h0000_1234);
    chk("rst0.wb_pass", wb_data, 32'h0000_5678);
    tick();
    tick();
    check_all("rst_edges");
    chk("rst_edges.instr", instr, 32'h0);

    // Release between edges, first capture on the next edge
    rst_n = 1'b1;
    tick();
    chk("rel.instr", instr, 32'h8C240008);

    // lw $4,8($1)
    mem_data = 32'hDEADBEEF;
    alu_out  = 32'h11;
    #1;
    check_all("lw");
    chk("lw.wr_reg", 32'(wr_reg), 32'd4);
    chk("lw.sx", sx_out, 32'h8);
    chk("lw.ctl", 32'(dut_ctl()), 32'(9'b0111100_00));
    chk("lw.wb", wb_data, 32'hDEADBEEF);
    chk("lw.alu_b", alu_b, 32'h8);

    // add $3,$1,$2 and funct variants
    load(32'h00221820);
    check_all("add");
    chk("add.fields", {17'b0, rs, rt, rd}, {17'b0, 5'd1, 5'd2, 5'd3});
    chk("add.wr_reg", 32'(wr_reg), 32'd3);
    chk("add.ctl", 32'(dut_ctl()), 32'(9'b1001000_00));
    chk("add.alu_b", alu_b, read_data2);
    chk("add.wb", wb_data, alu_out);
    load(32'h00221822);
    chk("sub.alu_op", 32'(alu_op), 32'd1);
    load(32'h00221824);
    chk("and.alu_op", 32'(alu_op), 32'd2);
    load(32'h00221825);
    chk("or.alu_op", 32'(alu_op), 32'd3);
    check_all("or");
    load(32'h00221800);
    chk("nop.ctl", 32'(dut_ctl()), 32'h0);
    check_all("nop");

    // sw $4,-4($1)
    load(32'hAC24FFFC);
    check_all("sw");
    chk("sw.sx", sx_out, 32'hFFFFFFFC);
    chk("sw.alu_b", alu_b, 32'hFFFFFFFC);
    chk("sw.ctl", 32'(dut_ctl()), 32'(9'b0100010_00));

    // beq $1,$2,-2
    load(32'h1022FFFE);
    check_all("beq");
    chk("beq.ctl", 32'(dut_ctl()), 32'(9'b0000001_01));
    chk("beq.sx", sx_out, 32'hFFFFFFFE);

    // addi $5,$1,-1
    load(32'h2025FFFF);
    check_all("addi");
    chk("addi.ctl", 32'(dut_ctl()), 32'(9'b0101000_00));
    chk("addi.wr_reg", 32'(wr_reg), 32'd5);

    // Unknown opcode
    load(32'hFC000000);
    check_all("unk");
    chk("unk.ctl", 32'(dut_ctl()), 32'h0);

    // Hold: IR frozen while instr_in toggles; muxes still follow inputs
    load(32'h8C240008);
    instr_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr_in   = $urandom;
      read_data2 = $urandom;
      alu_out    = $urandom;
      mem_data   = $urandom;
      tick();
      check_all("hold");
      chk("hold.instr", instr, 32'h8C240008);
    end
    load(32'h00221820);
    instr_en = 1'b0;
    read_data2 = 32'hCAFE0001;
    alu_out    = 32'hBEEF0002;
    #1;
    chk("track.alu_b", alu_b, 32'hCAFE0001);
    chk("track.wb", wb_data, 32'hBEEF0002);

    // Reset asserted mid-cycle clears IR without a clock edge
    load(32'hAC24FFFC);
    #2;
    rst_n = 1'b0;
    m_ir  = 32'h0;
    #1;
    check_all("midrst");
    chk("midrst.instr", instr, 32'h0);
    instr_in = 32'h1022FFFE;
    instr_en = 1'b1;
    tick();
    check_all("midrst_edge");
    rst_n = 1'b1;
    tick();
    chk("midrst_rel.instr", instr, 32'h1022FFFE);

    // Randomized instructions against the model
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      w[31:26] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) != 0) w[5:0] = fns[$urandom_range(0, 4)];
      if (w[31:26] == 6'h3F && $urandom_range(0, 1) == 1) w[31:26] = 6'($urandom);
      instr_in   = w;
      instr_en   = ($urandom_range(0, 3) != 0);
      read_data2 = $urandom;
      alu_out    = $urandom;
      mem_data   = $urandom;
      tick();
      check_all("rnd");
      read_data2 = $urandom;
      alu_out    = $urandom;
      mem_data   = $urandom;
      #1;
      check_all("rnd_mux");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
